spi_ram_master: RTL
===================

Name: spi_ram_master

Overview:
Parametrised SPI master for serial SRAMs (23LC-style READ 0x03 / WRITE 0x02), successor to the fixed single-byte read path in tt_um_spi_example. Adds write transactions, burst transfers of 1..MAX_BURST bytes, configurable address width and a configurable SCK divider. Sits between core logic (start/ready handshake, byte streams) and the uio SPI pins (cs_n, mosi, miso, sck).

Parameters:
ADDR_W, 8, address width in bits; sent as AB = ceil(ADDR_W/8) bytes, MSB first, zero-extended.
MAX_BURST, 4, maximum bytes per transaction (power of two, >=1).
CLK_DIV, 2, clk cycles per SCK half-period (>=1).
CS_IDLE, 2, minimum clk cycles cs_n stays high between transactions.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; accepted only when busy=0
we  input  1  1=WRITE (0x02), 0=READ (0x03); latched at accept
addr  input  ADDR_W  start address; latched at accept
len  input  LEN_W=max(1,clog2(MAX_BURST))  byte count minus 1; latched at accept
wdata  input  8  write byte; sampled in the cycle wdata_ready=1
wdata_ready  output  1  one-cycle pulse: wdata consumed
rdata  output  8  last received byte; holds until next byte
rdata_valid  output  1  one-cycle pulse: rdata updated
busy  output  1  high from accept to done
done  output  1  one-cycle pulse at transaction end
cs_n  output  1  SPI chip select, active low
sck  output  1  SPI clock, mode 0
mosi  output  1  SPI data out
miso  input  1  SPI data in

Behaviour:
- Reset (async, any state incl. mid-transfer): cs_n=1, sck=0, mosi=0, busy=0, done=0, wdata_ready=0, rdata_valid=0, rdata=0, state=IDLE, idle counter satisfied. No partial byte completion after reset release.
- Mode 0: sck idles low; mosi changes only while sck low (on falling edge / before first rise); miso sampled on sck rising edge; MSB first throughout.
- States: IDLE -> CMD (8 bits) -> ADDR (8*AB bits) -> DATA (8*(len+1) bits) -> FINISH -> IDLE.
- IDLE: start=1 && busy=0 latches we/addr/len, sets busy=1 next cycle, cs_n=0 and first mosi bit driven same cycle. start while busy is ignored (no queueing).
- Bit timing: each bit = 2*CLK_DIV clk cycles: CLK_DIV cycles sck=0 (setup), CLK_DIV cycles sck=1. Next bit driven on the falling edge that ends the previous bit.
- CMD byte: 0x02 if we else 0x03. ADDR bytes: {zero-pad, addr}, most significant byte first.
- WRITE data: wdata_ready pulses in the cycle each data byte is loaded into the shift register (first at end of last ADDR bit, subsequent at end of previous data byte's last bit); exactly len+1 pulses.
- READ data: mosi=0 during DATA. After the 8th rising-edge sample of each byte, rdata updated and rdata_valid pulses next clk; exactly len+1 pulses. No pulses on WRITE.
- FINISH: after last bit's high phase, sck=0, hold CLK_DIV cycles, then cs_n=1; done pulses and busy drops in the same cycle cs_n rises.
- CS_IDLE: new start accepted only after cs_n has been high >= CS_IDLE cycles; start before that is ignored (busy stays 0 but idle_ok gates accept; start must be re-asserted).
- Burst: address not incremented by master; RAM sequential mode advances. len=MAX_BURST-1 is the max; no wrap logic in master.
- Total sck rising edges per transaction = 8*(1+AB+len+1).

Test Plan:
- Reset values: rst_n=0 -> cs_n=1, sck=0, mosi=0, busy=0, done=0; hold 5 clk, no toggles.
- Single read, ADDR_W=8, CLK_DIV=2, ram.mem[0x12]=0xA5, addr=0x12, len=0 -> mosi bytes 0x03,0x12; 24 sck rises; one rdata_valid with rdata=0xA5; done one pulse; cs_n low for 96+ clk.
- Burst write then read: write addr=0x40, len=3, wdata stream 0x11,0x22,0x33,0x44 -> exactly 4 wdata_ready pulses, ram.mem[0x40..0x43] match; read back len=3 -> rdata_valid sequence 0x11,0x22,0x33,0x44.
- Wide address: ADDR_W=16, addr=0x0123, read -> mosi 0x03,0x01,0x23; 32 sck rises for len=0.
- Start while busy and within CS_IDLE window -> ignored: exactly one CMD per accepted start, cs_n high >= CS_IDLE between transactions.
- Reset mid-DATA on a burst read -> cs_n=1, sck=0 immediately (async), no rdata_valid/done; subsequent read at 0x12 returns 0xA5 correctly.

Source files
------------

// File: rtl/spi_ram_master.sv
// spi_ram_master
//   SPI mode-0 master for 23LC-style serial SRAMs. Issues READ (0x03) or
//   WRITE (0x02), then ceil(ADDR_W/8) address bytes MSB first, then a burst
//   of len+1 data bytes. The RAM advances its own address in sequential mode,
//   so the master never increments the address.
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   start         request pulse, accepted in IDLE once cs_n has been high
//                 for at least CS_IDLE cycles
//   we, addr, len transaction type, start address, byte count minus 1
//                 (all latched at accept)
//   wdata         write byte, sampled in the cycle wdata_ready is high
//   wdata_ready   one-cycle pulse: wdata loaded into the shift register
//   rdata         last received byte, holds until the next one
//   rdata_valid   one-cycle pulse: rdata updated
//   busy          high from accept until done
//   done          one-cycle pulse, coincides with cs_n rising
//   cs_n, sck, mosi, miso   SPI pins (mode 0, MSB first)
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | cs_n high, idle counter runs, waits for start
// S_CMD    | shifting the 8-bit command byte
// S_ADDR   | shifting AB address bytes, most significant first
// S_DATA   | shifting len+1 data bytes (write out or read in)
// S_FINISH | sck low for CLK_DIV cycles before cs_n is released

module spi_ram_master #(
   parameter int  ADDR_W    = 8,
   parameter int  MAX_BURST = 4,
   parameter int  CLK_DIV   = 2,
   parameter int  CS_IDLE   = 2,
   localparam int LEN_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [LEN_W-1:0]  len,
   input  logic [7:0]        wdata,
   output logic              wdata_ready,
   output logic [7:0]        rdata,
   output logic              rdata_valid,
   output logic              busy,
   output logic              done,
   output logic              cs_n,
   output logic              sck,
   output logic              mosi,
   input  logic              miso
);

   localparam int AB     = (ADDR_W + 7) / 8;
   localparam int APAD_W = AB * 8;
   localparam int ABC_W  = (AB > 1) ? $clog2(AB) : 1;
   localparam int CNT_W  = (LEN_W > ABC_W) ? LEN_W : ABC_W;
   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IDL_W  = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

   localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] AB_LAST   = CNT_W'(AB - 1);
   localparam logic [IDL_W-1:0] IDLE_LOAD = IDL_W'((CS_IDLE > 0) ? CS_IDLE - 1 : 0);
   localparam logic [7:0]       CMD_WRITE = 8'h02;
   localparam logic [7:0]       CMD_READ  = 8'h03;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_FINISH
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [7:0]        sr;
   logic [6:0]        rx;
   logic [APAD_W-1:0] addr_sr;
   logic [2:0]        bit_cnt;
   logic [CNT_W-1:0]  byte_cnt;
   logic [DIV_W-1:0]  div_cnt;
   logic [IDL_W-1:0]  idle_cnt;
   logic              we_r;
   logic [LEN_W-1:0]  len_r;

   logic shifting;
   logic tick;
   logic fall;
   logic byte_end;
   logic last_byte;
   logic idle_ok;
   logic accept;

   // tick marks the terminal count of the half-period timer; in the shifting
   // states it toggles sck, in FINISH it releases cs_n.
   assign shifting  = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);
   assign tick      = (div_cnt == '0);
   assign fall      = shifting && tick && sck;
   assign byte_end  = fall && (bit_cnt == 3'd0);
   assign last_byte = (byte_cnt == '0);
   assign idle_ok   = (idle_cnt == '0);
   assign accept    = (state == S_IDLE) && start && idle_ok;

   // cs_n is registered from the next state so it never glitches on the pin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cs_n  <= 1'b1;
      end else begin
         state <= state_nxt;
         cs_n  <= (state_nxt == S_IDLE);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept) state_nxt = S_CMD;
         S_CMD:    if (byte_end) state_nxt = S_ADDR;
         S_ADDR:   if (byte_end && last_byte) state_nxt = S_DATA;
         S_DATA:   if (byte_end && last_byte) state_nxt = S_FINISH;
         S_FINISH: if (tick) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // mosi comes straight from the shift register MSB; sr is cleared outside
   // of CMD/ADDR/write-DATA so the pin rests at 0.
   always_comb begin
      busy        = (state != S_IDLE);
      mosi        = sr[7];
      wdata_ready = 1'b0;
      if (we_r && byte_end) begin
         if ((state == S_ADDR) && last_byte)
            wdata_ready = 1'b1;
         if ((state == S_DATA) && !last_byte)
            wdata_ready = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck         <= 1'b0;
         sr          <= '0;
         rx          <= '0;
         addr_sr     <= '0;
         bit_cnt     <= '0;
         byte_cnt    <= '0;
         div_cnt     <= '0;
         idle_cnt    <= '0;
         we_r        <= 1'b0;
         len_r       <= '0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
         done        <= 1'b0;
      end else begin
         rdata_valid <= 1'b0;
         done        <= 1'b0;
         case (state)
            S_IDLE: begin
               sck <= 1'b0;
               if (!idle_ok)
                  idle_cnt <= idle_cnt - IDL_W'(1);
               if (accept) begin
                  we_r    <= we;
                  len_r   <= len;
                  addr_sr <= APAD_W'(addr);
                  sr      <= we ? CMD_WRITE : CMD_READ;
                  bit_cnt <= 3'd7;
                  div_cnt <= DIV_LOAD;
               end
            end

            S_FINISH: begin
               if (tick) begin
                  done     <= 1'b1;
                  idle_cnt <= IDLE_LOAD;
               end else begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end
            end

            default: begin
               if (!tick) begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end else begin
                  div_cnt <= DIV_LOAD;
                  sck     <= ~sck;
                  if (!sck) begin
                     // rising edge: sample miso; the 8th sample of a read
                     // data byte completes rdata
                     rx <= {rx[5:0], miso};
                     if ((state == S_DATA) && !we_r && (bit_cnt == 3'd0)) begin
                        rdata       <= {rx, miso};
                        rdata_valid <= 1'b1;
                     end
                  end else if (bit_cnt != 3'd0) begin
                     bit_cnt <= bit_cnt - 3'd1;
                     sr      <= {sr[6:0], 1'b0};
                  end else begin
                     // falling edge closing a byte: load the next one
                     bit_cnt <= 3'd7;
                     case (state)
                        S_CMD: begin
                           sr       <= addr_sr[APAD_W-1 -: 8];
                           addr_sr  <= addr_sr << 8;
                           byte_cnt <= AB_LAST;
                        end
                        S_ADDR: begin
                           if (!last_byte) begin
                              sr       <= addr_sr[APAD_W-1 -: 8];
                              addr_sr  <= addr_sr << 8;
                              byte_cnt <= byte_cnt - CNT_W'(1);
                           end else begin
                              sr       <= we_r ? wdata : 8'h00;
                              byte_cnt <= CNT_W'(len_r);
                           end
                        end
                        default: begin
                           if (!last_byte) begin
                              sr       <= we_r ? wdata : 8'h00;
                              byte_cnt <= byte_cnt - CNT_W'(1);
                           end else begin
                              sr <= 8'h00;
                           end
                        end
                     endcase
                  end
               end
            end
         endcase
      end
   end

endmodule
